// File: rtl/vram_fetch_pkg.sv
// Shared types and width helpers for the VRAM line fetcher.
// Holds the fetch FSM encoding and default-derived widths.
package vram_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int LINE_BYTES_DEF = 40;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH_DEF);
  localparam int CNT_W   = $clog2(LINE_BYTES_DEF + 1);

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vram_line_fetcher_fifo.sv
// First-word-fall-through line FIFO between RAM return and pixel shifter.
// Ports: clk_sys/reset, flush, push/din, pop/dout, empty, count.
module sync_fifo_fwft
  import vram_fetch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_W-1:0]      din,
  input  logic                   pop,
  output logic [DATA_W-1:0]      dout,
  output logic                   empty,
  output logic [aw_of(DEPTH):0]  count
);

  localparam int AW = aw_of(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop & (cnt_q != '0);
    do_push  = push & ((cnt_q != FULL) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push & ~do_pop) cnt_d = cnt_q + (AW+1)'(1);
      if (do_pop & ~do_push) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push & ~flush & ~reset) mem_q[wr_ptr_q] <= din;
  end

  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  // Drive zero when empty so nothing stale leaks out after reset/flush.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vram_line_fetcher.sv
// Scan-line fetcher: reads LINE_BYTES bytes from line_base via RAM port B
// into a FWFT FIFO feeding the pixel shifter; flags overrun/underrun.
module vram_line_fetcher
  import vram_fetch_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int LINE_BYTES = 40,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              overrun,
  output logic              underrun
);

  localparam int FAW = aw_of(FIFO_DEPTH);
  localparam int CW  = cnt_w_of(LINE_BYTES);
  localparam logic [CW-1:0]  LAST  = CW'(LINE_BYTES - 1);
  localparam logic [FAW+1:0] LIMIT = (FAW+2)'(FIFO_DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic [FAW:0]      fifo_count;
  logic [FAW+1:0]    credit_used;
  logic              fifo_empty;
  logic              busy_w, restart, issue;

  assign busy_w  = (state_q != IDLE);
  assign restart = line_start & busy_w;

  // Count the in-flight byte so its push can never hit a full FIFO.
  assign credit_used = {1'b0, fifo_count} + {{(FAW+1){1'b0}}, inflight_q};
  assign issue = (state_q == FETCH) & (credit_used < LIMIT)
               & ~line_start & ~reset;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    inflight_d = issue;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (issue) begin
      addr_d   = base_q + ADDR_W'(issued_q);
      issued_d = issued_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          base_d   = line_base;
          issued_d = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (issue && issued_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      base_d    = line_base;
      issued_d  = '0;
      state_d   = FETCH;
      overrun_d = 1'b1;
    end

    if (pix_ready & busy_w & fifo_empty) underrun_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // A restart drops the returning byte of the abandoned line.
  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (restart),
    .push    (inflight_q & ~restart),
    .din     (ram_q),
    .pop     (pix_ready),
    .dout    (pix_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign ram_rd    = issue;
  assign ram_addr  = addr_d;
  assign pix_valid = ~fifo_empty;
  assign busy      = busy_w;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Self-checking bench for vram_line_fetcher: vector table, corner
// sequences and random traffic against a queue-based line model.
module tb_vram_line_fetcher;

  localparam int LB = 40;
  localparam int FD = 16;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       line_start = 1'b0;
  logic [9:0] line_base = '0;
  logic [9:0] ram_addr;
  logic       ram_rd;
  logic [7:0] ram_q = '0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic       busy, overrun, underrun;

  vram_line_fetcher dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .line_start (line_start),
    .line_base  (line_base),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_q      (ram_q),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .overrun    (overrun),
    .underrun   (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] rv(input int a);
    int b;
    b = a & 1023;
    return 8'((b * 37) ^ (b >> 3) ^ 8'h5A);
  endfunction

  logic [7:0] ram [1024];

  always @(posedge clk_sys) begin
    if (ram_rd) ram_q <= ram[ram_addr];
  end

  // Line model: expected FIFO contents and per-line read bookkeeping.
  logic [7:0] q_fifo [$];
  bit         chk_en = 1'b0;
  bit         active = 1'b0;
  bit         pend = 1'b0;
  logic [7:0] pend_val = '0;
  bit         exp_ov = 1'b0;
  bit         exp_un = 1'b0;
  int         n_rd = 0;
  int         cur_base = 0;
  int         last_rd = -10;
  int         cyc = 0;
  int         pops_line = 0;
  int         rd_total = 0;
  logic [7:0] first_b = '0;
  logic [7:0] last_b = '0;

  always @(negedge clk_sys) begin
    bit mbusy;
    bit mempty;
    cyc++;
    mbusy  = active && !(n_rd == LB && cyc > last_rd + 2);
    mempty = (q_fifo.size() == 0);
    if (chk_en) begin
      chk("busy", busy, mbusy);
      chk("overrun", overrun, exp_ov);
      chk("underrun", underrun, exp_un);
      chk("pix_valid", pix_valid, !mempty);
      if (!mempty) chk("pix_data", pix_data, q_fifo[0]);
      if (ram_rd) begin
        chk("ram_addr", ram_addr, (cur_base + n_rd) % 1024);
        chk("rd_in_line", active && n_rd < LB, 1);
      end
    end
    if (pix_ready && !mempty) begin
      if (pops_line == 0) first_b = q_fifo[0];
      last_b = q_fifo[0];
      pops_line++;
      void'(q_fifo.pop_front());
    end
    if (pix_ready && mempty && mbusy) exp_un = 1'b1;
    if (line_start && mbusy) begin
      exp_ov = 1'b1;
      q_fifo.delete();
      pend = 1'b0;
    end
    if (pend) begin
      q_fifo.push_back(pend_val);
      pend = 1'b0;
      if (chk_en) chk("fifo_bound", q_fifo.size() <= FD, 1);
    end
    if (ram_rd) begin
      pend     = 1'b1;
      pend_val = rv(cur_base + n_rd);
      n_rd++;
      rd_total++;
      if (n_rd == LB) last_rd = cyc;
    end
    if (active && !mbusy) active = 1'b0;
    if (line_start) begin
      active   = 1'b1;
      n_rd     = 0;
      cur_base = int'(line_base);
      last_rd  = -10;
    end
    if (reset) begin
      q_fifo.delete();
      pend   = 1'b0;
      active = 1'b0;
      n_rd   = 0;
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    line_start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_line(input logic [9:0] b);
    line_base  = b;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_rd"}, ram_rd, 0);
    chk({tag, "_data"}, pix_data, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_udr"}, underrun, 0);
  endtask

  typedef struct {
    logic [9:0] base;
    int         stall;
    int         exp_rd;
    logic       exp_un;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cnt;
    for (int i = 0; i < 1024; i++) ram[i] = rv(i);
    vecs[0] = '{10'h100, 50, 16, 1'b0, rv(10'h100), rv(10'h100 + 39)};
    vecs[1] = '{10'h3F0, 50, 16, 1'b0, rv(10'h3F0), rv(10'h017)};
    vecs[2] = '{10'h000, 0, 0, 1'b1, rv(10'h000), rv(10'h027)};
    vecs[3] = '{10'h3E5, 20, 16, 1'b0, rv(10'h3E5), rv(10'h00C)};

    do_reset();
    chk_en = 1'b1;
    chk_all_zero("rst");

    foreach (vecs[v]) begin
      do_reset();
      pops_line = 0;
      rd_total  = 0;
      pix_ready = (vecs[v].stall == 0);
      start_line(vecs[v].base);
      if (vecs[v].stall > 0) begin
        for (int k = 1; k < vecs[v].stall; k++) tick();
        chk("stall_reads", rd_total, vecs[v].exp_rd);
        chk("stall_rd_low", ram_rd, 0);
        pix_ready = 1'b1;
      end
      for (int k = 0; k < 600 && !(pops_line >= LB && !busy); k++) tick();
      tick();
      chk("line_pops", pops_line, LB);
      chk("line_reads", rd_total, LB);
      chk("line_first", first_b, vecs[v].exp_first);
      chk("line_last", last_b, vecs[v].exp_last);
      chk("line_udr", underrun, vecs[v].exp_un);
      chk("line_ovr", overrun, 0);
      chk("line_busy", busy, 0);
    end

    // Sticky underrun survives idle time, clears on reset.
    for (int k = 0; k < 30; k++) tick();
    do_reset();
    pix_ready = 1'b1;
    start_line(10'h000);
    for (int k = 0; k < 100; k++) tick();
    chk("udr_sticky", underrun, 1);
    do_reset();
    chk("udr_cleared", underrun, 0);

    // Restart during the tenth read of a line.
    pix_ready = 1'b1;
    start_line(10'h100);
    cnt = 0;
    while (!(ram_rd && ram_addr == 10'h109) && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("ovr_found_rd10", cnt < 100, 1);
    line_base  = 10'h200;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_fifo_empty", pix_valid, 0);
    cnt = 0;
    while (!pix_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("ovr_restart_byte", pix_data, rv(10'h200));
    for (int k = 0; k < 100; k++) tick();
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of fetching.
    do_reset();
    pix_ready = 1'b0;
    start_line(10'h050);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("midrst");
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (ram_rd) cnt++;
      tick();
    end
    chk("midrst_no_rd", cnt, 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      pix_ready  = ($urandom_range(0, 3) != 0);
      line_start = ($urandom_range(0, 59) == 0);
      line_base  = 10'($urandom);
      reset      = ($urandom_range(0, 699) == 0);
      tick();
    end
    line_start = 1'b0;
    reset      = 1'b0;
    pix_ready  = 1'b1;
    for (int k = 0; k < 200; k++) tick();
    chk("rand_end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
